// File: rtl/brom_rr_arbiter.sv
// Round-robin arbiter that shares one fixed-latency ROM among NUM_REQ read requesters.
// The grant is combinational; a LAT-deep valid pipeline routes the ROM data back to the winner.
module brom_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LAT     = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   idx;
    logic [NUM_REQ-1:0] pipe_reg [LAT];
    logic [ADDR_W-1:0]  addr_masked [NUM_REQ];

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
        if (reset) begin
            grant    = '0;
            ptr_next = '0;
        end
    end

    assign req_ready = grant;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_mask
        assign addr_masked[gi] = grant[gi] ? req_addr[gi*ADDR_W +: ADDR_W] : '0;
    end

    // The grant is one-hot or zero, so an OR-reduction of masked addresses is a clean mux.
    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rom_addr = rom_addr | addr_masked[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_reg[0] <= '0;
        end else begin
            pipe_reg[0] <= grant;
        end
    end

    for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
        always_ff @(posedge clock) begin
            if (reset) begin
                pipe_reg[gi] <= '0;
            end else begin
                pipe_reg[gi] <= pipe_reg[gi-1];
            end
        end
    end

    assign rsp_valid = reset ? '0 : pipe_reg[LAT-1];
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_brom_rr_arbiter.sv
// Drives three arbiter instances (LAT 1, 2, 3) with shared directed stimulus and
// checks grants, ROM address and responses against a queued reference model.
module tb_brom_rr_arbiter;

    typedef struct {
        int         due;
        logic [3:0] vec;
        logic [7:0] data;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_addr = '0;

    logic [3:0] req_ready_w [3];
    logic [3:0] rsp_valid_w [3];
    logic [7:0] rsp_data_w  [3];
    logic [7:0] rom_addr_w  [3];
    logic [7:0] rom_data_w  [3];

    logic [7:0] rom_p1, rom_p2a, rom_p2b, rom_p3a, rom_p3b, rom_p3c;

    rsp_t sb [3][$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   model_ptr = 0;
    logic [3:0] exp_ready;
    logic [7:0] exp_addr;

    always #5 clock = ~clock;

    brom_rr_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LAT(1)) u_lat1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_w[0]), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
        .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0])
    );
    brom_rr_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LAT(2)) u_lat2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_w[1]), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
        .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1])
    );
    brom_rr_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_w[2]), .rsp_valid(rsp_valid_w[2]), .rsp_data(rsp_data_w[2]),
        .rom_addr(rom_addr_w[2]), .rom_data(rom_data_w[2])
    );

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return (a * 8'd13) ^ 8'hA5;
    endfunction

    // ROM models: sample address on the rising edge, data appears LAT cycles later.
    always @(posedge clock) begin
        rom_p1  <= rom_f(rom_addr_w[0]);
        rom_p2a <= rom_f(rom_addr_w[1]);
        rom_p2b <= rom_p2a;
        rom_p3a <= rom_f(rom_addr_w[2]);
        rom_p3b <= rom_p3a;
        rom_p3c <= rom_p3b;
    end
    assign rom_data_w[0] = rom_p1;
    assign rom_data_w[1] = rom_p2b;
    assign rom_data_w[2] = rom_p3c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] addrs);
        rsp_t e;
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        @(posedge clock);
        #1;
        cyc++;
        reset     = rst;
        req_valid = v;
        req_addr  = addrs;
        exp_ready = '0;
        exp_addr  = '0;
        if (rst) begin
            model_ptr = 0;
            for (int l = 0; l < 3; l++) begin
                while (sb[l].size() > 0 && sb[l][sb[l].size()-1].due >= cyc) begin
                    void'(sb[l].pop_back());
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (model_ptr + k) % 4;
                if (exp_ready == 4'b0000 && v[j]) begin
                    exp_ready = 4'b0001 << j;
                    exp_addr  = addrs[j*8 +: 8];
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (exp_ready[k]) model_ptr = (k + 1) % 4;
            end
            if (exp_ready != 4'b0000) begin
                for (int l = 0; l < 3; l++) begin
                    e.due  = cyc + l + 1;
                    e.vec  = exp_ready;
                    e.data = rom_f(exp_addr);
                    sb[l].push_back(e);
                end
            end
        end
        @(negedge clock);
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("ready_lat%0d", l + 1), 32'(req_ready_w[l]), 32'(exp_ready));
            chk($sformatf("rom_addr_lat%0d", l + 1), 32'(rom_addr_w[l]), 32'(exp_addr));
            exp_v = '0;
            exp_d = '0;
            if (sb[l].size() > 0 && sb[l][0].due == cyc) begin
                e     = sb[l].pop_front();
                exp_v = e.vec;
                exp_d = e.data;
            end
            chk($sformatf("rsp_valid_lat%0d", l + 1), 32'(rsp_valid_w[l]), 32'(exp_v));
            if (exp_v != 4'b0000) begin
                chk($sformatf("rsp_data_lat%0d", l + 1), 32'(rsp_data_w[l]), 32'(exp_d));
            end
            $display("cyc=%0d lat=%0d rst=%0b valid=%b ready=%b rom_addr=%h rsp_valid=%b rsp_data=%h",
                     cyc, l + 1, rst, v, req_ready_w[l], rom_addr_w[l], rsp_valid_w[l], rsp_data_w[l]);
        end
    endtask

    initial begin
        // Reset holds outputs low even with every requester asserting valid.
        step(1'b1, 4'b1111, 32'h40302010);
        step(1'b1, 4'b1111, 32'h40302010);

        // Idle: no grant, zero address, no responses.
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 32'hDEADBEEF);

        // Single requester streaming every address.
        for (int i = 0; i < 256; i++) step(1'b0, 4'b0001, {$urandom() & 32'hFFFFFF00} | 32'(i));
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 32'h0);

        // Reset restores priority to requester 0, then full contention.
        step(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 32'h40302010);

        // Pointer wrap after requester 3, skipping idle requesters.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, 32'h44332211);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 32'h0);

        // Random traffic including requests that drop before being granted.
        for (int i = 0; i < 60; i++) step(1'b0, 4'($urandom_range(0, 15)), $urandom());

        // Reset mid-flight discards pending responses; requester 0 then wins.
        step(1'b0, 4'b0010, 32'h00005500);
        step(1'b1, 4'b1111, 32'h0);
        step(1'b0, 4'b1111, 32'hA4A3A2A1);
        step(1'b0, 4'b1111, 32'hA4A3A2A1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 32'h0);

        for (int l = 0; l < 3; l++) begin
            chk($sformatf("drained_lat%0d", l + 1), 32'(sb[l].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/brom_rr_arbiter.md
BROM_RR_ARBITER -- requirements
Module: brom_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the ROM address width (256 entries).
REQ-003 SHALL have parameter DATA_W, default 8, meaning the ROM data width.
REQ-004 SHALL have parameter LAT, default 1, meaning the ROM read latency in cycles from address sample to data valid (legal range 1..4).
REQ-005 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester read request valid.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  per-requester read address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester grant; the request is accepted in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle wide.
REQ-011 SHALL have port rsp_data  output  DATA_W  response data, shared by all requesters.
REQ-012 SHALL have port rom_addr  output  ADDR_W  address driven to the shared ROM, which samples it on the rising edge.
REQ-013 SHALL have port rom_data  input  DATA_W  ROM read data, valid LAT cycles after the address is sampled.

Function
REQ-014 SHALL grant at most one requester per cycle; req_ready SHALL be zero or one-hot.
REQ-015 SHALL compute req_ready combinationally from req_valid and the round-robin pointer, with no dependence on req_ready inputs from requesters.
REQ-016 SHALL search for the grant winner starting at index ptr, then ptr+1, and so on, wrapping modulo NUM_REQ; the first requester with valid=1 wins.
REQ-017 SHALL hold ptr unchanged when no requester is granted, and SHALL set ptr to (winner+1) mod NUM_REQ after a grant, so the pointer wraps from NUM_REQ-1 to 0.
REQ-018 SHALL drive rom_addr to the granted requester's req_addr in the grant cycle, and to all zeros when there is no grant.
REQ-019 SHALL carry the one-hot grant vector through a LAT-stage shift register of valid bits; stage contents SHALL advance every cycle, with no stall.
REQ-020 SHALL assert rsp_valid equal to the grant vector exactly LAT cycles after the grant cycle, with rsp_data = rom_data in that same cycle.
REQ-021 SHALL sustain a throughput of one accepted request per cycle; back-to-back grants SHALL produce back-to-back responses in grant order.
REQ-022 SHALL accept no response backpressure; requesters SHALL capture the response in the cycle rsp_valid is asserted.
REQ-023 SHALL ensure that a requester whose valid stays high while others contend is granted within NUM_REQ cycles (starvation-free).
REQ-024 SHALL ensure that a req_valid dropped before a grant leaves no side effect; no partial request is retained.
REQ-025 SHALL drive rsp_data from rom_data unconditionally; rsp_data content is don't-care when rsp_valid is zero.

Reset
REQ-026 SHALL, while reset is high, set ptr to 0 and clear all pipeline valid bits, and SHALL force req_ready to 0, rsp_valid to 0 and rom_addr to 0 in the same cycle, independent of req_valid.
REQ-027 SHALL discard in-flight requests when reset is asserted mid-operation; no rsp_valid SHALL appear for them after reset deasserts.
REQ-028 SHALL let requester 0 have first priority in the first cycle after reset deasserts.

Verification
REQ-029 SHALL be verified with a single requester: NUM_REQ=4, LAT=1, req_valid=0001, addr 0x00..0xFF on consecutive cycles -> ready=0001 every cycle; rsp_valid[0] one cycle later with rsp_data = ROM[addr], 256 responses in order.
REQ-030 SHALL be verified with full contention: req_valid=1111 held for 8 cycles with addrs 0x10/0x20/0x30/0x40 -> grants in order 0,1,2,3,0,1,2,3; rsp_data = ROM[0x10], ROM[0x20], and so on, each one cycle later.
REQ-031 SHALL be verified for pointer wrap and skip: after a grant to requester 3, with req_valid=0101 -> grant to requester 0, then 2, then 0.
REQ-032 SHALL be verified for LAT=3: grant at cycle t -> rsp_valid at t+3 only, with rsp_valid zero at t+1 and t+2.
REQ-033 SHALL be verified for reset mid-flight: LAT=2, grant at t, reset high at t+1 for 1 cycle -> no rsp_valid at t+2; first grant after reset goes to requester 0 when req_valid=1111.
REQ-034 SHALL be verified for idle: req_valid=0000 -> rom_addr=0x00, req_ready=0000, and rsp_valid=0000 LAT cycles later.
